// File: rtl/router_port_drain.sv
// router_port_drain: drains one router output port into a packet stream.
// Reads header, payload and parity bytes, checks parity, counts packets.
//
// Ports:
//   clock, reset   single clock, async active-high reset
//   vld_out        router port FIFO not empty
//   data_out[7:0]  router read data, valid the cycle after read_enb
//   sink_ready     consumer can accept a byte; low stalls new reads
//   read_enb       read strobe to router port (combinational)
//   pkt_byte[7:0]  payload byte, qualified by pkt_byte_vld
//   pkt_byte_vld   one-cycle strobe per payload byte
//   pkt_addr[1:0]  header address of the current packet
//   pkt_len[5:0]   header length of the current packet
//   pkt_done       one-cycle pulse after the parity byte is checked
//   parity_err     valid with pkt_done; parity mismatch or zero length
//   pkt_abort      one-cycle pulse when vld_out drops mid-packet
//   pkt_count[7:0] good packets, wrapping
//   err_count[7:0] errored plus aborted packets, saturating
module router_port_drain #(
  parameter int READ_DELAY = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       sink_ready,
  output logic       read_enb,
  output logic [7:0] pkt_byte,
  output logic       pkt_byte_vld,
  output logic [1:0] pkt_addr,
  output logic [5:0] pkt_len,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       pkt_abort,
  output logic [7:0] pkt_count,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    HDR,
    BODY,
    DONE
  } state_t;

  localparam logic [4:0] DLY_LOAD =
    (READ_DELAY > 0) ? 5'(READ_DELAY - 1) : 5'd0;

  state_t     state;
  logic [4:0] dly_cnt;
  logic       hdr_issued;
  logic [6:0] reads_left;
  logic [6:0] caps_left;
  logic       cap_pend;
  logic [7:0] acc;
  logic       want_rd;
  logic [6:0] body_cnt;

  // Byte count after the header: payload plus parity.
  assign body_cnt = {1'b0, data_out[7:2]} + 7'd1;

  always_comb begin
    want_rd = 1'b0;
    unique case (1'b1)
      (state == HDR):  want_rd = !hdr_issued;
      (state == BODY): want_rd = (reads_left != 7'd0);
      default:         want_rd = 1'b0;
    endcase
  end

  // Gated by reset so the strobe drops the instant reset rises.
  assign read_enb = want_rd && vld_out && sink_ready && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      dly_cnt      <= 5'd0;
      hdr_issued   <= 1'b0;
      reads_left   <= 7'd0;
      caps_left    <= 7'd0;
      cap_pend     <= 1'b0;
      acc          <= 8'd0;
      pkt_byte     <= 8'd0;
      pkt_byte_vld <= 1'b0;
      pkt_addr     <= 2'd0;
      pkt_len      <= 6'd0;
      pkt_done     <= 1'b0;
      parity_err   <= 1'b0;
      pkt_abort    <= 1'b0;
      pkt_count    <= 8'd0;
      err_count    <= 8'd0;
    end else begin
      pkt_byte_vld <= 1'b0;
      pkt_done     <= 1'b0;
      parity_err   <= 1'b0;
      pkt_abort    <= 1'b0;
      // A read this cycle means a capture next cycle.
      cap_pend     <= read_enb;
      unique case (state)
        IDLE: begin
          hdr_issued <= 1'b0;
          dly_cnt    <= DLY_LOAD;
          if (vld_out) begin
            if (READ_DELAY > 0) begin
              state <= WAIT;
            end else begin
              state <= HDR;
            end
          end
        end
        WAIT: begin
          if (!vld_out) begin
            state <= IDLE;
          end else if (dly_cnt == 5'd0) begin
            state <= HDR;
          end else begin
            dly_cnt <= dly_cnt - 5'd1;
          end
        end
        HDR: begin
          if (read_enb) begin
            hdr_issued <= 1'b1;
          end
          if (cap_pend) begin
            pkt_len    <= data_out[7:2];
            pkt_addr   <= data_out[1:0];
            acc        <= data_out;
            reads_left <= body_cnt;
            caps_left  <= body_cnt;
            state      <= BODY;
          end
        end
        BODY: begin
          if (read_enb) begin
            reads_left <= reads_left - 7'd1;
          end
          if (cap_pend) begin
            caps_left <= caps_left - 7'd1;
            if (caps_left == 7'd1) begin
              // Last byte of the packet is parity.
              parity_err <= (data_out != acc) ||
                            (pkt_len == 6'd0);
              pkt_done   <= 1'b1;
              state      <= DONE;
            end else begin
              pkt_byte     <= data_out;
              pkt_byte_vld <= 1'b1;
              acc          <= acc ^ data_out;
            end
          end else if (!vld_out &&
                       reads_left != 7'd0) begin
            // Router emptied before the packet ended.
            pkt_abort  <= 1'b1;
            cap_pend   <= 1'b0;
            reads_left <= 7'd0;
            caps_left  <= 7'd0;
            state      <= IDLE;
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
          end
        end
        DONE: begin
          if (parity_err) begin
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
          end else begin
            pkt_count <= pkt_count + 8'd1;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
